// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
package pipe_ctrl_pkg;

  localparam int unsigned DefaultTimeout = 64;
  localparam int unsigned DefaultCntW    = 32;

  typedef enum logic [1:0] {
    StRun,
    StMemWait,
    StErr
  } state_e;

  // Pipeline-register control bundle, one bit per EN/FLUSH line.
  typedef struct packed {
    logic en_f;
    logic en_d;
    logic en_e;
    logic en_m;
    logic flush_d;
    logic flush_e;
    logic flush_w;
  } ctrl_t;

  // Free-running pipeline.
  localparam ctrl_t CtrlRun = '{en_f: 1'b1, en_d: 1'b1, en_e: 1'b1, en_m: 1'b1,
                                flush_d: 1'b0, flush_e: 1'b0, flush_w: 1'b0};
  // Whole pipe frozen, bubble into writeback (memory wait and error trap).
  localparam ctrl_t CtrlHold = '{en_f: 1'b0, en_d: 1'b0, en_e: 1'b0, en_m: 1'b0,
                                 flush_d: 1'b0, flush_e: 1'b0, flush_w: 1'b1};
  // Taken control transfer: squash Fetch and Decode.
  localparam ctrl_t CtrlFlush = '{en_f: 1'b1, en_d: 1'b1, en_e: 1'b1, en_m: 1'b1,
                                  flush_d: 1'b1, flush_e: 1'b1, flush_w: 1'b0};
  // Load-use: hold front end, bubble into Execute.
  localparam ctrl_t CtrlLoadUse = '{en_f: 1'b0, en_d: 1'b0, en_e: 1'b1, en_m: 1'b1,
                                    flush_d: 1'b0, flush_e: 1'b1, flush_w: 1'b0};
  // Reset: nothing advances, every stage register is cleared.
  localparam ctrl_t CtrlReset = '{en_f: 1'b0, en_d: 1'b0, en_e: 1'b0, en_m: 1'b0,
                                  flush_d: 1'b1, flush_e: 1'b1, flush_w: 1'b1};

endpackage

// File: rtl/pipe_hazard_sequencer_if.sv
// Hazard inputs and pipeline controls between the core datapath and the sequencer.
interface pipe_hazard_sequencer_if
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = DefaultCntW
);
  logic [4:0]       Rs1D;
  logic [4:0]       Rs2D;
  logic [4:0]       RdE;
  logic             MemReadE;
  logic             RegWriteE;
  logic             PCSrcE;
  logic             DMemReqM;
  logic             DMemReadyM;
  logic             CntClr;
  logic             EN_F;
  logic             EN_D;
  logic             EN_E;
  logic             EN_M;
  logic             FLUSH_D;
  logic             FLUSH_E;
  logic             FLUSH_W;
  logic             MemErr;
  logic [CNT_W-1:0] StallCnt;
  logic [CNT_W-1:0] FlushCnt;

  // Datapath side.
  modport master (
    output Rs1D, Rs2D, RdE, MemReadE, RegWriteE, PCSrcE, DMemReqM, DMemReadyM, CntClr,
    input  EN_F, EN_D, EN_E, EN_M, FLUSH_D, FLUSH_E, FLUSH_W, MemErr, StallCnt, FlushCnt
  );

  // Sequencer side.
  modport slave (
    input  Rs1D, Rs2D, RdE, MemReadE, RegWriteE, PCSrcE, DMemReqM, DMemReadyM, CntClr,
    output EN_F, EN_D, EN_E, EN_M, FLUSH_D, FLUSH_E, FLUSH_W, MemErr, StallCnt, FlushCnt
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [Width-1:0] count
);

  logic [Width-1:0] count_q;

  // Count events, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_hazard_sequencer.sv
// Central pipeline controller: stall/flush decode, data-memory wait FSM and debug counters.
module pipe_hazard_sequencer
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = DefaultTimeout,
  parameter int unsigned CNT_W   = DefaultCntW
) (
  input logic                    clk,
  input logic                    rst,
  pipe_hazard_sequencer_if.slave bus
);

  localparam int unsigned WaitW = $clog2(TIMEOUT + 1);

  state_e           state_q;
  logic [WaitW-1:0] wait_q;
  logic             mem_err_q;

  logic             memstall;
  logic             loaduse;
  logic             flush_take;
  logic             stall_inc;
  ctrl_t            ctrl;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  assign memstall = bus.DMemReqM & ~bus.DMemReadyM;
  // x0 is never a real producer, so it cannot create a load-use dependency.
  assign loaduse  = bus.MemReadE & bus.RegWriteE & (bus.RdE != 5'd0) &
                    ((bus.RdE == bus.Rs1D) | (bus.RdE == bus.Rs2D));

  // Prioritised control decode; a pending branch waits out a memory stall because Execute is frozen.
  always_comb begin
    ctrl       = CtrlRun;
    flush_take = 1'b0;
    if (rst) begin
      ctrl = CtrlReset;
    end else if (state_q == StErr) begin
      ctrl = CtrlHold;
    end else if (memstall) begin
      ctrl = CtrlHold;
    end else if (bus.PCSrcE) begin
      ctrl       = CtrlFlush;
      flush_take = 1'b1;
    end else if (loaduse) begin
      ctrl = CtrlLoadUse;
    end
  end

  // Wait-state sequencing and sticky timeout trap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StRun;
      wait_q    <= '0;
      mem_err_q <= 1'b0;
    end else begin
      case (state_q)
        StRun: begin
          if (memstall) begin
            state_q <= StMemWait;
            wait_q  <= WaitW'(1);
          end
        end
        StMemWait: begin
          if (!memstall) begin
            state_q <= StRun;
            wait_q  <= '0;
          end else if (wait_q == WaitW'(TIMEOUT)) begin
            state_q   <= StErr;
            mem_err_q <= 1'b1;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        StErr: begin
          state_q <= StErr;
        end
        default: begin
          state_q <= StRun;
          wait_q  <= '0;
        end
      endcase
    end
  end

  // Error cycles are a dead pipe, not a stall worth counting.
  assign stall_inc = ~ctrl.en_f & ~rst & (state_q != StErr);

  sat_counter #(
    .Width (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .clr   (bus.CntClr),
    .count (stall_cnt)
  );

  sat_counter #(
    .Width (CNT_W)
  ) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_take),
    .clr   (bus.CntClr),
    .count (flush_cnt)
  );

  assign bus.EN_F     = ctrl.en_f;
  assign bus.EN_D     = ctrl.en_d;
  assign bus.EN_E     = ctrl.en_e;
  assign bus.EN_M     = ctrl.en_m;
  assign bus.FLUSH_D  = ctrl.flush_d;
  assign bus.FLUSH_E  = ctrl.flush_e;
  assign bus.FLUSH_W  = ctrl.flush_w;
  assign bus.MemErr   = mem_err_q;
  assign bus.StallCnt = stall_cnt;
  assign bus.FlushCnt = flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_sequencer.sv
// Directed-vector bench for pipe_hazard_sequencer (TIMEOUT=4, CNT_W=4).
module tb_pipe_hazard_sequencer;

  localparam int unsigned Timeout = 4;
  localparam int unsigned CntW    = 4;

  // {EN_F, EN_D, EN_E, EN_M, FLUSH_D, FLUSH_E, FLUSH_W}
  localparam logic [6:0] ExpRun   = 7'b1111_000;
  localparam logic [6:0] ExpHold  = 7'b0000_001;
  localparam logic [6:0] ExpFlush = 7'b1111_110;
  localparam logic [6:0] ExpLu    = 7'b0011_010;
  localparam logic [6:0] ExpRst   = 7'b0000_111;

  logic clk;
  logic rst;
  int   vectors;
  int   errors;

  pipe_hazard_sequencer_if #(.CNT_W(CntW)) bus ();

  pipe_hazard_sequencer #(
    .TIMEOUT (Timeout),
    .CNT_W   (CntW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [6:0] obs();
    return {bus.EN_F, bus.EN_D, bus.EN_E, bus.EN_M, bus.FLUSH_D, bus.FLUSH_E, bus.FLUSH_W};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    bus.Rs1D       = 5'd0;
    bus.Rs2D       = 5'd0;
    bus.RdE        = 5'd0;
    bus.MemReadE   = 1'b0;
    bus.RegWriteE  = 1'b0;
    bus.PCSrcE     = 1'b0;
    bus.DMemReqM   = 1'b0;
    bus.DMemReadyM = 1'b0;
    bus.CntClr     = 1'b0;
  endtask

  task automatic set_loaduse(input logic [4:0] rd);
    bus.MemReadE  = 1'b1;
    bus.RegWriteE = 1'b1;
    bus.RdE       = rd;
    bus.Rs2D      = rd;
    bus.Rs1D      = rd + 5'd1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors++;
    if (obs() !== ExpRst) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want %b", obs(), ExpRst);
    end
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({obs(), bus.MemErr, bus.StallCnt, bus.FlushCnt} !== {ExpRun, 1'b0, 4'd0, 4'd0}) begin
      errors++;
      $display("FAIL reset_state: got %b/%b/%0d/%0d want %b/0/0/0",
               obs(), bus.MemErr, bus.StallCnt, bus.FlushCnt, ExpRun);
    end
    next_cycle();
    bus.DMemReqM = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (obs() !== ExpHold) begin
        errors++;
        $display("FAIL reset_prewait%0d: got %b want %b", i, obs(), ExpHold);
      end
      next_cycle();
    end
    // Reset lands mid-wait with the memory stall still asserted.
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({obs(), bus.StallCnt} !== {ExpRst, 4'd3}) begin
      errors++;
      $display("FAIL reset_midwait: got %b/%0d want %b/3", obs(), bus.StallCnt, ExpRst);
    end
    next_cycle();
    rst = 1'b0;
    set_idle();
    @(negedge clk);
    vectors++;
    if ({obs(), bus.MemErr, bus.StallCnt, bus.FlushCnt} !== {ExpRun, 1'b0, 4'd0, 4'd0}) begin
      errors++;
      $display("FAIL reset_after: got %b/%b/%0d/%0d want %b/0/0/0",
               obs(), bus.MemErr, bus.StallCnt, bus.FlushCnt, ExpRun);
    end
    next_cycle();
  endtask

  task automatic test_load_use();
    set_loaduse(5'd5);
    @(negedge clk);
    vectors++;
    if (obs() !== ExpLu) begin
      errors++;
      $display("FAIL loaduse_stall: got %b want %b", obs(), ExpLu);
    end
    next_cycle();
    set_idle();
    @(negedge clk);
    vectors++;
    if ({obs(), bus.StallCnt} !== {ExpRun, 4'd1}) begin
      errors++;
      $display("FAIL loaduse_release: got %b/%0d want %b/1", obs(), bus.StallCnt, ExpRun);
    end
    next_cycle();
    // rd = x0 never stalls.
    bus.MemReadE  = 1'b1;
    bus.RegWriteE = 1'b1;
    @(negedge clk);
    vectors++;
    if (obs() !== ExpRun) begin
      errors++;
      $display("FAIL loaduse_x0: got %b want %b", obs(), ExpRun);
    end
    next_cycle();
    // Load without register write does not stall.
    bus.RdE       = 5'd7;
    bus.Rs1D      = 5'd7;
    bus.RegWriteE = 1'b0;
    @(negedge clk);
    vectors++;
    if (obs() !== ExpRun) begin
      errors++;
      $display("FAIL loaduse_nowrite: got %b want %b", obs(), ExpRun);
    end
    next_cycle();
    // ALU producer matching rs1 is forwarded, not stalled.
    bus.RegWriteE = 1'b1;
    bus.MemReadE  = 1'b0;
    @(negedge clk);
    vectors++;
    if (obs() !== ExpRun) begin
      errors++;
      $display("FAIL loaduse_alu: got %b want %b", obs(), ExpRun);
    end
    next_cycle();
    set_idle();
    @(negedge clk);
    vectors++;
    if (bus.StallCnt !== 4'd1) begin
      errors++;
      $display("FAIL loaduse_count: got %0d want 1", bus.StallCnt);
    end
    next_cycle();
  endtask

  task automatic test_branch_loaduse();
    set_loaduse(5'd9);
    bus.PCSrcE = 1'b1;
    @(negedge clk);
    vectors++;
    if (obs() !== ExpFlush) begin
      errors++;
      $display("FAIL branch_lu_ctrl: got %b want %b", obs(), ExpFlush);
    end
    next_cycle();
    set_idle();
    @(negedge clk);
    vectors++;
    if ({bus.FlushCnt, bus.StallCnt} !== {4'd1, 4'd1}) begin
      errors++;
      $display("FAIL branch_lu_count: got flush %0d stall %0d want 1 1",
               bus.FlushCnt, bus.StallCnt);
    end
    next_cycle();
  endtask

  task automatic test_cnt_clr();
    // Clear coincides with a stall event: the event is dropped.
    set_loaduse(5'd3);
    bus.CntClr = 1'b1;
    @(negedge clk);
    vectors++;
    if (obs() !== ExpLu) begin
      errors++;
      $display("FAIL clr_ctrl: got %b want %b", obs(), ExpLu);
    end
    next_cycle();
    set_idle();
    @(negedge clk);
    vectors++;
    if ({bus.StallCnt, bus.FlushCnt} !== {4'd0, 4'd0}) begin
      errors++;
      $display("FAIL clr_count: got stall %0d flush %0d want 0 0", bus.StallCnt, bus.FlushCnt);
    end
    next_cycle();
  endtask

  task automatic test_mem_wait_branch();
    bus.DMemReqM = 1'b1;
    bus.PCSrcE   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (obs() !== ExpHold) begin
        errors++;
        $display("FAIL memwait_hold%0d: got %b want %b", i, obs(), ExpHold);
      end
      next_cycle();
    end
    bus.DMemReadyM = 1'b1;
    @(negedge clk);
    vectors++;
    if (obs() !== ExpFlush) begin
      errors++;
      $display("FAIL memwait_flush: got %b want %b", obs(), ExpFlush);
    end
    next_cycle();
    set_idle();
    @(negedge clk);
    vectors++;
    if ({bus.StallCnt, bus.FlushCnt, bus.MemErr} !== {4'd3, 4'd1, 1'b0}) begin
      errors++;
      $display("FAIL memwait_count: got stall %0d flush %0d err %b want 3 1 0",
               bus.StallCnt, bus.FlushCnt, bus.MemErr);
    end
    next_cycle();
    // Zero-wait access never stalls.
    bus.DMemReqM   = 1'b1;
    bus.DMemReadyM = 1'b1;
    @(negedge clk);
    vectors++;
    if (obs() !== ExpRun) begin
      errors++;
      $display("FAIL zero_wait: got %b want %b", obs(), ExpRun);
    end
    next_cycle();
    set_idle();
    @(negedge clk);
    vectors++;
    if (bus.StallCnt !== 4'd3) begin
      errors++;
      $display("FAIL zero_wait_count: got %0d want 3", bus.StallCnt);
    end
    next_cycle();
  endtask

  task automatic test_timeout();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    bus.DMemReqM = 1'b1;
    // Wait counter reaches TIMEOUT during the 5th stalled cycle; trap at its end.
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      vectors++;
      if ({obs(), bus.MemErr} !== {ExpHold, 1'b0}) begin
        errors++;
        $display("FAIL timeout_wait%0d: got %b/%b want %b/0", i, obs(), bus.MemErr, ExpHold);
      end
      next_cycle();
    end
    @(negedge clk);
    vectors++;
    if ({obs(), bus.MemErr, bus.StallCnt} !== {ExpHold, 1'b1, 4'd5}) begin
      errors++;
      $display("FAIL timeout_trap: got %b/%b/%0d want %b/1/5",
               obs(), bus.MemErr, bus.StallCnt, ExpHold);
    end
    next_cycle();
    // Error state ignores the memory, branches and load-use alike.
    set_idle();
    set_loaduse(5'd4);
    bus.PCSrcE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if ({obs(), bus.MemErr, bus.StallCnt, bus.FlushCnt} !== {ExpHold, 1'b1, 4'd5, 4'd0}) begin
        errors++;
        $display("FAIL err_hold%0d: got %b/%b/%0d/%0d want %b/1/5/0",
                 i, obs(), bus.MemErr, bus.StallCnt, bus.FlushCnt, ExpHold);
      end
      next_cycle();
    end
    rst = 1'b1;
    set_idle();
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({obs(), bus.MemErr, bus.StallCnt} !== {ExpRun, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL err_exit: got %b/%b/%0d want %b/0/0", obs(), bus.MemErr, bus.StallCnt, ExpRun);
    end
    next_cycle();
  endtask

  task automatic test_saturation();
    set_loaduse(5'd6);
    for (int i = 0; i < 20; i++) next_cycle();
    set_idle();
    bus.PCSrcE = 1'b1;
    for (int i = 0; i < 18; i++) next_cycle();
    set_idle();
    @(negedge clk);
    vectors++;
    if ({bus.StallCnt, bus.FlushCnt} !== {4'd15, 4'd15}) begin
      errors++;
      $display("FAIL sat_hold: got stall %0d flush %0d want 15 15", bus.StallCnt, bus.FlushCnt);
    end
    next_cycle();
    bus.CntClr = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.StallCnt !== 4'd15) begin
      errors++;
      $display("FAIL sat_preclr: got %0d want 15", bus.StallCnt);
    end
    next_cycle();
    bus.CntClr = 1'b0;
    @(negedge clk);
    vectors++;
    if ({bus.StallCnt, bus.FlushCnt} !== {4'd0, 4'd0}) begin
      errors++;
      $display("FAIL sat_clr: got stall %0d flush %0d want 0 0", bus.StallCnt, bus.FlushCnt);
    end
    next_cycle();
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    rst     = 1'b1;
    set_idle();
    test_reset();
    test_load_use();
    test_branch_loaduse();
    test_cnt_clr();
    test_mem_wait_branch();
    test_timeout();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_sequencer.md
Name: pipe_hazard_sequencer

Overview:
- Central pipeline controller for the 5-stage RV32I core.
- Generates the EN/FLUSH controls for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Sequences load-use stalls, taken branch/jump flushes and data-memory wait states.
- Detects a data-memory timeout and latches a fatal error.
- Keeps saturating stall and flush event counters for debug and performance.

Parameters:
- TIMEOUT, 64: maximum data-memory wait cycles before the error trap (must be ≥ 1).
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- Rs1D  in  5  rs1 of the instruction in Decode
- Rs2D  in  5  rs2 of the instruction in Decode
- RdE  in  5  rd of the instruction in Execute
- MemReadE  in  1  Execute instruction is a load
- RegWriteE  in  1  Execute instruction writes the RF
- PCSrcE  in  1  taken branch or jump resolved in Execute
- DMemReqM  in  1  Memory stage has an active data-memory access
- DMemReadyM  in  1  data memory completes the access this cycle
- CntClr  in  1  synchronous clear of both counters
- EN_F  out  1  PC register enable
- EN_D  out  1  IF/ID enable
- EN_E  out  1  ID/EX enable
- EN_M  out  1  EX/MEM enable
- FLUSH_D  out  1  IF/ID flush
- FLUSH_E  out  1  ID/EX flush
- FLUSH_W  out  1  MEM/WB bubble insert
- MemErr  out  1  sticky data-memory timeout flag
- StallCnt  out  CNT_W  cycles with EN_F=0, excluding reset and ERR
- FlushCnt  out  CNT_W  accepted control-transfer flushes

Behaviour:
- Reset (rst=1, at any time including mid-wait):
  - state=RUN, wait counter=0, MemErr=0, StallCnt=0, FlushCnt=0.
  - While rst=1, all EN_* outputs are 0 and FLUSH_D=FLUSH_E=FLUSH_W=1.
- States: RUN, MEM_WAIT, ERR. The controls are a combinational decode of state and inputs, with zero latency (they act in the same cycle).
- Derived terms:
  - memstall = DMemReqM & ~DMemReadyM.
  - loaduse = MemReadE & RegWriteE & (RdE≠0) & (RdE==Rs1D | RdE==Rs2D).
- Output priority, highest first:
  1. ERR: all EN=0; FLUSH_D=FLUSH_E=0; FLUSH_W=1.
  2. memstall (RUN or MEM_WAIT): EN_F=EN_D=EN_E=EN_M=0; FLUSH_D=FLUSH_E=0; FLUSH_W=1. A pending PCSrcE is held, because Execute is frozen, and acted on after the stall.
  3. PCSrcE: all EN=1; FLUSH_D=FLUSH_E=1; FLUSH_W=0. This overrides loaduse, since the Decode instruction is discarded anyway.
  4. loaduse: EN_F=EN_D=0; EN_E=EN_M=1; FLUSH_E=1; FLUSH_D=FLUSH_W=0.
  5. Otherwise: all EN=1 and all FLUSH=0.
- Transitions:
  - RUN → MEM_WAIT on memstall; wait counter is loaded with 1.
  - MEM_WAIT → RUN when DMemReadyM=1, or when DMemReqM drops; wait counter is cleared.
  - MEM_WAIT with memstall: counter increments. When counter==TIMEOUT with memstall still true, go to ERR and set MemErr=1.
  - ERR is held until rst.
  - A zero-wait access (req & ready in the same cycle) never leaves RUN.
- Counters:
  - Width CNT_W, saturating at all-ones; no wrap-around.
  - StallCnt increments each cycle EN_F=0 while not in rst and not in ERR.
  - FlushCnt increments each cycle priority level 3 is active.
  - CntClr has priority over increment: that cycle the counter is zeroed and the event is not counted.
- RdE=0 never produces a load-use stall.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - state enum (RUN/MEM_WAIT/ERR);
  - default TIMEOUT and CNT_W constants;
  - control-bundle struct {en_f, en_d, en_e, en_m, flush_d, flush_e, flush_w}.
- Natural sub-module: sat_counter (parameterised width, inc, clr), instantiated twice.
- Hazard decode and the FSM stay in the top module.

Test Plan:
- Reset mid-MEM_WAIT (counter=5):
  - Stimulus: assert rst for 1 cycle.
  - Response: that cycle all EN=0 and all FLUSH=1. Next cycle state=RUN, counters=0, MemErr=0.
- Load-use:
  - Stimulus: MemReadE=1, RegWriteE=1, RdE=5, Rs2D=5.
  - Response: EN_F=EN_D=0, FLUSH_E=1 for exactly 1 cycle; StallCnt=1.
  - Repeat with RdE=0: no stall.
- Branch plus load-use conflict:
  - Stimulus: PCSrcE=1 together with a loaduse match.
  - Response: EN_F=1, FLUSH_D=FLUSH_E=1; FlushCnt increments by 1.
- Memory wait of 3 cycles with PCSrcE=1:
  - Stimulus: DMemReqM=1, DMemReadyM=0 for 3 cycles, with PCSrcE=1 throughout.
  - Response: all EN=0 and FLUSH_W=1 for 3 cycles; then the flush is applied in cycle 4. StallCnt=3, FlushCnt=1.
- Timeout with TIMEOUT=4:
  - Stimulus: DMemReqM held high with DMemReadyM=0.
  - Response: MemErr rises after the 4th wait cycle and stays high with EN=0 until rst.
- Saturation with CNT_W=4:
  - Stimulus: force 20 stall cycles, then pulse CntClr.
  - Response: StallCnt holds at 15, then reads 0 after the clear cycle.
